// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter shared types: FSM state, read-return owner, IO region bit.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PIPE = 2'd1,
    OWN_EXT  = 2'd2
  } rd_owner_t;

  localparam int IO_BIT = 7;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline, external requester and shared RAM/IO bus signals of the MEM port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [31:0]       p_wdata;
  logic              p_stall;
  logic [31:0]       p_rdata;
  logic              p_rvalid;

  logic              e_req;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_wdata;
  logic              e_gnt;
  logic              e_err;
  logic [31:0]       e_rdata;
  logic              e_rvalid;

  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_we;
  logic [31:0]       bus_rdata;

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    output e_req, e_we, e_addr, e_wdata,
    output bus_rdata,
    input  p_stall, p_rdata, p_rvalid,
    input  e_gnt, e_err, e_rdata, e_rvalid,
    input  bus_addr, bus_wdata, bus_we
  );

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    input  e_req, e_we, e_addr, e_wdata,
    input  bus_rdata,
    output p_stall, p_rdata, p_rvalid,
    output e_gnt, e_err, e_rdata, e_rvalid,
    output bus_addr, bus_wdata, bus_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// MEM-stage data port arbiter: pipeline first, external side forced after MAX_WAIT.
// Optional MEMARB_IO_PROTECT_EN refuses external accesses to the IO region.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 32
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave port
);

  arb_state_t state;
  logic [3:0] wait_cnt;
  rd_owner_t  rd_owner;
  rd_owner_t  own;
  logic [31:0] p_q;
  logic [31:0] e_q;

  logic ext_want;
  logic ext_blk;
  logic gnt;
  logic err;
  logic stall;
  logic p_rv;
  logic e_rv;

`ifdef MEMARB_IO_PROTECT_EN
  assign ext_blk = port.e_addr[IO_BIT];
`else
  assign ext_blk = 1'b0;
`endif

  assign ext_want = port.e_req &&
    (!port.p_req || state == ST_FORCE);

  always_comb begin
    own   = OWN_NONE;
    gnt   = 1'b0;
    err   = 1'b0;
    stall = 1'b0;
    if (!reset) begin
      if (ext_want && ext_blk) begin
        // refused access leaves the port to the pipeline
        err = 1'b1;
        own = port.p_req ? OWN_PIPE : OWN_NONE;
      end else if (ext_want) begin
        gnt   = 1'b1;
        own   = OWN_EXT;
        stall = port.p_req;
      end else if (port.p_req) begin
        own = OWN_PIPE;
      end
    end
  end

  always_comb begin
    port.bus_we    = 1'b0;
    port.bus_addr  = '0;
    port.bus_wdata = '0;
    unique case (own)
      OWN_PIPE: begin
        port.bus_we    = port.p_we;
        port.bus_addr  = port.p_addr;
        port.bus_wdata = port.p_wdata;
      end
      OWN_EXT: begin
        port.bus_we    = port.e_we;
        port.bus_addr  = port.e_addr;
        port.bus_wdata = port.e_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else if (gnt || err || !port.e_req) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      // e_req high and lost to the pipeline this cycle
      if (wait_cnt != 4'hF)
        wait_cnt <= wait_cnt + 4'd1;
      if (32'(wait_cnt) + 32'd1 >= 32'(MAX_WAIT))
        state <= ST_FORCE;
      else
        state <= ST_WAIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_owner <= OWN_NONE;
      p_q      <= '0;
      e_q      <= '0;
    end else begin
      if (own == OWN_PIPE && !port.p_we)
        rd_owner <= OWN_PIPE;
      else if (own == OWN_EXT && !port.e_we)
        rd_owner <= OWN_EXT;
      else
        rd_owner <= OWN_NONE;
      if (p_rv) p_q <= port.bus_rdata;
      if (e_rv) e_q <= port.bus_rdata;
    end
  end

  assign p_rv = !reset && rd_owner == OWN_PIPE;
  assign e_rv = !reset && rd_owner == OWN_EXT;

  assign port.p_stall  = stall;
  assign port.e_gnt    = gnt;
  assign port.e_err    = err;
  assign port.p_rvalid = p_rv;
  assign port.e_rvalid = e_rv;
  assign port.p_rdata  = p_rv ? port.bus_rdata : p_q;
  assign port.e_rdata  = e_rv ? port.bus_rdata : e_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MAX_WAIT=4).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32)) mif ();

  mem_port_arbiter #(
    .MAX_WAIT(4),
    .ADDR_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .port(mif)
  );

  typedef struct {
    bit          ext;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_p = '0;
  logic [31:0] last_e = '0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'h5A00_0000 + 32'(k) * 32'h0001_1111;
  endfunction

  task automatic step(input bit pr, input bit pw,
                      input logic [31:0] pa, input logic [31:0] pd,
                      input bit er, input bit ew,
                      input logic [31:0] ea, input logic [31:0] ed,
                      input bit x_gnt, input bit x_stall,
                      input bit x_err);
    bit          own_p;
    bit          own_e;
    logic        x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wd;
    rd_exp_t     e;
    mif.p_req     = pr;
    mif.p_we      = pw;
    mif.p_addr    = pa;
    mif.p_wdata   = pd;
    mif.e_req     = er;
    mif.e_we      = ew;
    mif.e_addr    = ea;
    mif.e_wdata   = ed;
    mif.bus_rdata = pat(cyc);
    @(negedge clock);
    check("e_gnt", 32'(mif.e_gnt), 32'(x_gnt));
    check("p_stall", 32'(mif.p_stall), 32'(x_stall));
    check("e_err", 32'(mif.e_err), 32'(x_err));
    own_e  = x_gnt;
    own_p  = pr && !x_stall && !reset;
    x_we   = own_e ? ew : (own_p ? pw : 1'b0);
    x_addr = own_e ? ea : (own_p ? pa : 32'd0);
    x_wd   = own_e ? ed : (own_p ? pd : 32'd0);
    check("bus_we", 32'(mif.bus_we), 32'(x_we));
    check("bus_addr", mif.bus_addr, x_addr);
    check("bus_wdata", mif.bus_wdata, x_wd);
    if (reset) begin
      exp_q.delete();
      check("p_rvalid_rst", 32'(mif.p_rvalid), 32'd0);
      check("e_rvalid_rst", 32'(mif.e_rvalid), 32'd0);
      check("p_rdata_rst", mif.p_rdata, last_p);
      check("e_rdata_rst", mif.e_rdata, last_e);
      last_p = '0;
      last_e = '0;
    end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.ext) begin
        check("e_rvalid", 32'(mif.e_rvalid), 32'd1);
        check("e_rdata", mif.e_rdata, e.data);
        check("p_rvalid_idle", 32'(mif.p_rvalid), 32'd0);
        check("p_rdata_hold", mif.p_rdata, last_p);
        last_e = e.data;
      end else begin
        check("p_rvalid", 32'(mif.p_rvalid), 32'd1);
        check("p_rdata", mif.p_rdata, e.data);
        check("e_rvalid_idle", 32'(mif.e_rvalid), 32'd0);
        check("e_rdata_hold", mif.e_rdata, last_e);
        last_p = e.data;
      end
    end else begin
      check("p_rvalid_none", 32'(mif.p_rvalid), 32'd0);
      check("e_rvalid_none", 32'(mif.e_rvalid), 32'd0);
      check("p_rdata_hold", mif.p_rdata, last_p);
      check("e_rdata_hold", mif.e_rdata, last_e);
    end
    if (!reset && own_p && !pw)
      exp_q.push_back('{ext: 1'b0, data: pat(cyc + 1), due: cyc + 1});
    if (!reset && own_e && !ew)
      exp_q.push_back('{ext: 1'b1, data: pat(cyc + 1), due: cyc + 1});
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    mif.p_req     = 0;
    mif.p_we      = 0;
    mif.p_addr    = '0;
    mif.p_wdata   = '0;
    mif.e_req     = 0;
    mif.e_we      = 0;
    mif.e_addr    = '0;
    mif.e_wdata   = '0;
    mif.bus_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    idle();
    reset = 1'b0;
    idle();

    // external load alone, then back-to-back external loads
    step(0, 0, 0, 0, 1, 0, 32'h10, 0, 1, 0, 0);
    idle();
    step(0, 0, 0, 0, 1, 0, 32'h10, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h14, 0, 1, 0, 0);
    idle();

    // continuous pipeline loads vs external store: forced in cycle 4
    for (int i = 0; i < 5; i++)
      step(1, 0, 32'h100 + 32'(i) * 4, 0,
           1, 1, 32'h200, 32'h1234_5678,
           i == 4, i == 4, 0);
    step(1, 0, 32'h120, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // pipeline load then external load
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h44, 0, 1, 0, 0);
    idle();

    // pipeline store to IO region
    step(1, 1, 32'h80, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // external store to IO region
`ifdef MEMARB_IO_PROTECT_EN
    step(0, 0, 0, 0, 1, 1, 32'h84, 32'hCAFE_F00D, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 32'h84, 0, 0, 0, 1);
`else
    step(0, 0, 0, 0, 1, 1, 32'h84, 32'hCAFE_F00D, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h84, 0, 1, 0, 0);
`endif
    idle();

    // reset in the cycle after a granted load
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single data-memory/IO port of the pipelined CPU's MEM stage between the pipeline itself and one external requester (debug/DMA loader). Pipeline has fixed priority, and a wait counter guarantees the external side a slot. The block drives the shared RAM/IO bus, steers the one-cycle-late read data back to the winner and stalls the pipeline when the external side holds the port. It sits between the MEM-stage register outputs and the data RAM / IO register bank.

## Interface
- MAX_WAIT, 4: cycles an external request may wait before it is forced through (1..15).
- ADDR_W, 32: address width on all ports.

- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- p_req  in  1  pipeline MEM stage has a load/store this cycle.
- p_we  in  1  pipeline store.
- p_addr  in  32  pipeline byte address (malu); bit 7 = IO region.
- p_wdata  in  32  pipeline store data (mb).
- p_stall  out  1  pipeline must hold MEM stage this cycle.
- p_rdata  out  32  pipeline load data.
- p_rvalid  out  1  p_rdata valid (cycle after pipeline grant, loads only).
- e_req  in  1  external request; held high until e_gnt or e_err.
- e_we, e_addr[31:0], e_wdata[31:0]  in  external write flag, address, data.
- e_gnt  out  1  one-cycle pulse: external access issued this cycle.
- e_err  out  1  one-cycle pulse: external access refused (see Configuration).
- e_rdata  out  32  external load data.
- e_rvalid  out  1  e_rdata valid (cycle after e_gnt, loads only).
- bus_addr  out  32  shared port address.
- bus_wdata  out  32  shared port write data.
- bus_we  out  1  shared port write enable.
- bus_rdata  in  32  shared port read data, valid one cycle after address.

## Operation
- States: IDLE (no ext pending), WAIT (ext pending, pipeline busy), FORCE (ext forced this cycle).
- Per cycle, owner chosen combinationally:
  - no p_req, e_req: owner ext, e_gnt=1.
  - p_req, no e_req or state≠FORCE: owner pipe, p_stall=0.
  - state FORCE with e_req: owner ext, e_gnt=1, p_stall=1 if p_req.
- wait_cnt (4 bit): cleared on reset and on e_gnt/e_err; increments each cycle e_req is high and not served; saturates at 15.
- Transitions: IDLE→WAIT when e_req lost to pipe; WAIT→FORCE when wait_cnt+1 == MAX_WAIT; any→IDLE on e_gnt/e_err; FORCE with e_req dropped (protocol violation) → IDLE, no grant.
- bus_* driven from owner's inputs; when no owner, bus_we=0, bus_addr/bus_wdata=0.
- Read return: registered rd_owner (none/pipe/ext) records owner of a load; next cycle bus_rdata is copied to that side's rdata and its rvalid pulses. Other side's rdata holds its last value.
- Writes never produce rvalid.

## Timing
- Reset values: state IDLE, wait_cnt 0, rd_owner none, p_stall 0, p_rvalid 0, e_gnt 0, e_err 0, e_rvalid 0, p_rdata 0, e_rdata 0, bus_we 0.
- Grant/stall combinational same cycle; read latency exactly 1 cycle after grant.
- Back-to-back grants allowed; a read return and a new grant overlap in the same cycle.
- Max external wait = MAX_WAIT cycles of pipeline contention before grant.
- Reset asserted with a read in flight: rvalid suppressed, rd_owner cleared.
- p_stall high at most one cycle per forced external access.

## Configuration
- MEMARB_IO_PROTECT_EN defined: external request with e_addr[7]=1 never reaches the bus; when it would otherwise be granted, e_err pulses instead of e_gnt, bus_we stays 0, no e_rvalid, p_stall not asserted for it.
- Undefined: e_err tied 0; external side may read/write IO region like the pipeline.

## Structure
- Shared package: state encoding (IDLE/WAIT/FORCE), rd_owner encoding, IO region bit index (7).
- No sub-modules required; the wait counter may be a small `arb_wait_counter` sub-module if reused.

## Test plan
- Only e_req, e_we=0, e_addr=0x10 -> e_gnt same cycle, bus_addr=0x10, next cycle e_rvalid=1, e_rdata=bus_rdata.
- p_req continuous, e_req from cycle 0, MAX_WAIT=4 -> e_gnt with p_stall=1 in cycle 4, p_stall=0 in all other cycles.
- Pipeline load at cycle n, external load at n+1 -> p_rvalid at n+1, e_rvalid at n+2, data not swapped.
- Pipeline store p_addr=0x80, p_wdata=0xDEADBEEF -> bus_we=1, bus_addr=0x80, no p_rvalid.
- MEMARB_IO_PROTECT_EN, e_req with e_addr=0x84 and no p_req -> e_err pulse, e_gnt=0, bus_we=0; undefined -> e_gnt pulse.
- Reset during cycle after a granted load -> no rvalid next cycle, all outputs at reset values.
